// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC sequencer feeding a 2-entry {pc, instruction} queue to decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                   PC_WIDTH       = 64,
    parameter int                   MEM_ADDR_WIDTH = 10,
    parameter int                   DATA_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC       = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0]     i_mem_data,
    input  logic                      i_redirect_valid,
    input  logic [PC_WIDTH-1:0]       i_redirect_pc,
    output logic                      o_instr_valid,
    output logic [DATA_WIDTH-1:0]     o_instr,
    output logic [PC_WIDTH-1:0]       o_instr_pc,
    input  logic                      i_instr_ready
);

    localparam logic [PC_WIDTH-1:0] c_pc_step   = PC_WIDTH'(4);
    localparam logic [1:0]          c_depth     = 2'd2;

    logic [PC_WIDTH-1:0]   r_pc;
    logic [1:0]            r_count;
    logic                  r_head;
    logic                  r_tail;
    logic [PC_WIDTH-1:0]   r_q_pc    [2];
    logic [DATA_WIDTH-1:0] r_q_instr [2];

    logic                  w_pop;
    logic                  w_push;
    logic                  w_unused_redirect_lsbs;

    // Redirect targets are word aligned; the low two bits carry no meaning.
    assign w_unused_redirect_lsbs = ^i_redirect_pc[1:0];

    assign o_mem_addr    = r_pc[MEM_ADDR_WIDTH+1:2];
    assign o_instr_valid = (r_count != 2'd0);
    assign o_instr       = r_q_instr[r_head];
    assign o_instr_pc    = r_q_pc[r_head];

    assign w_pop  = o_instr_valid & i_instr_ready;
    assign w_push = ~i_redirect_valid & ((r_count < c_depth) | w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_pc    <= RESET_PC;
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else if (i_redirect_valid) begin
            // A pop in this cycle is considered consumed; the queue is flushed.
            r_pc    <= {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + c_pc_step;
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage is not reset; validity is carried solely by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_pc;
            r_q_instr[r_tail] <= i_mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_WIDTH       = 64;
    localparam int MEM_ADDR_WIDTH = 10;
    localparam int DATA_WIDTH     = 32;

    logic                      clk;
    logic                      rstn;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic                      redirect_valid;
    logic [PC_WIDTH-1:0]       redirect_pc;
    logic                      instr_valid;
    logic [DATA_WIDTH-1:0]     instr;
    logic [PC_WIDTH-1:0]       instr_pc;
    logic                      instr_ready;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_WIDTH       (PC_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .RESET_PC       ('0)
    ) dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .o_mem_addr       (mem_addr),
        .i_mem_data       (mem_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_instr_valid    (instr_valid),
        .o_instr          (instr),
        .o_instr_pc       (instr_pc),
        .i_instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: mem[k] = 0x1000_0000 + k
    assign mem_data = 32'h1000_0000 + {{(DATA_WIDTH-MEM_ADDR_WIDTH){1'b0}}, mem_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn           = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h500;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b want 0", instr_valid);
        end
        checks++;
        if (mem_addr !== 10'h0) begin
            errors++;
            $display("FAIL reset_over_redirect mem_addr got %0h want 0", mem_addr);
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        rstn           = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== 32'h1000_0000) begin
            errors++;
            $display("FAIL first_fetch got v=%0b pc=%0h instr=%0h want v=1 pc=0 instr=10000000",
                     instr_valid, instr_pc, instr);
        end
        checks++;
        if (mem_addr !== 10'h1) begin
            errors++;
            $display("FAIL first_fetch_addr got %0h want 1", mem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 64'(4 * k) ||
                instr !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL stream[%0d] got v=%0b pc=%0h instr=%0h want v=1 pc=%0h instr=%0h",
                         k, instr_valid, instr_pc, instr, 4 * k, 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== 32'h1000_0000) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%0b pc=%0h instr=%0h want v=1 pc=0 instr=10000000",
                         k, instr_valid, instr_pc, instr);
            end
        end
        checks++;
        if (mem_addr !== 10'h2) begin
            errors++;
            $display("FAIL stall_addr got %0h want 2", mem_addr);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 64'(4 * k)) begin
                errors++;
                $display("FAIL stall_drain[%0d] got v=%0b pc=%0h want v=1 pc=%0h",
                         k, instr_valid, instr_pc, 4 * k);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        instr_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== 10'h40) begin
            errors++;
            $display("FAIL redirect_flush got v=%0b addr=%0h want v=0 addr=40", instr_valid, mem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h100 || instr !== 32'h1000_0040) begin
            errors++;
            $display("FAIL redirect_target got v=%0b pc=%0h instr=%0h want v=1 pc=100 instr=10000040",
                     instr_valid, instr_pc, instr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== 10'h80) begin
            errors++;
            $display("FAIL redirect_unaligned got v=%0b addr=%0h want v=0 addr=80", instr_valid, mem_addr);
        end
        tick();
        checks++;
        if (instr_pc !== 64'h200 || instr !== 32'h1000_0080) begin
            errors++;
            $display("FAIL redirect_unaligned_pc got pc=%0h instr=%0h want pc=200 instr=10000080",
                     instr_pc, instr);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h8) begin
            errors++;
            $display("FAIL pop_pre got v=%0b pc=%0h want v=1 pc=8", instr_valid, instr_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_redirect_flush got v=%0b want 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h300) begin
            errors++;
            $display("FAIL pop_redirect_next got v=%0b pc=%0h want v=1 pc=300", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap_and_midreset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (mem_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL wrap_addr_top got %0h want 3ff", mem_addr);
        end
        tick();
        checks++;
        if (instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC || instr !== 32'h1000_03FF || mem_addr !== 10'h0) begin
            errors++;
            $display("FAIL wrap_top got pc=%0h instr=%0h addr=%0h want pc=fffffffffffffffc instr=100003ff addr=0",
                     instr_pc, instr, mem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== 32'h1000_0000) begin
            errors++;
            $display("FAIL wrap_zero got v=%0b pc=%0h instr=%0h want v=1 pc=0 instr=10000000",
                     instr_valid, instr_pc, instr);
        end
        tick();
        rstn = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got %0b want 0", instr_valid);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h0) begin
            errors++;
            $display("FAIL midreset_restart got v=%0b pc=%0h want v=1 pc=0", instr_valid, instr_pc);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_wrap_and_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 64, meaning program counter width.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning word-index width of instruction memory address.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning instruction width.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-005 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port i_rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port o_mem_addr  output  MEM_ADDR_WIDTH  word index to instruction memory.
REQ-008 SHALL have port i_mem_data  input  DATA_WIDTH  instruction word at o_mem_addr, same cycle (combinational memory read).
REQ-009 SHALL have port i_redirect_valid  input  1  branch/jump/trap redirect request.
REQ-010 SHALL have port i_redirect_pc  input  PC_WIDTH  redirect target.
REQ-011 SHALL have port o_instr_valid  output  1  queue head valid toward decode.
REQ-012 SHALL have port o_instr  output  DATA_WIDTH  queue head instruction.
REQ-013 SHALL have port o_instr_pc  output  PC_WIDTH  PC of queue head instruction.
REQ-014 SHALL have port i_instr_ready  input  1  decode accepts head this cycle.

Function
REQ-015 SHALL hold a PC register; o_mem_addr = pc[MEM_ADDR_WIDTH+1:2], combinational from pc.
REQ-016 SHALL contain a 2-entry FIFO of {pc, instruction}; o_instr_valid = (count != 0); o_instr/o_instr_pc = head entry.
REQ-017 SHALL define pop = o_instr_valid & i_instr_ready; push = ~i_redirect_valid & (count < 2 | pop).
REQ-018 SHALL, on push, write {pc, i_mem_data} at tail and set pc <= pc + 4 (modulo 2^PC_WIDTH, wrap to 0 without error).
REQ-019 SHALL, when push is 0 and no redirect, hold pc and o_mem_addr unchanged.
REQ-020 SHALL update count: +1 push only, -1 pop only, unchanged both or neither; count never exceeds 2 nor underflows.
REQ-021 SHALL give latency 1 cycle from PC presented on o_mem_addr to instruction valid at head when FIFO was empty.
REQ-022 SHALL sustain 1 instruction/cycle when i_instr_ready held high.
REQ-023 SHALL keep head stable (o_instr, o_instr_pc unchanged, valid high) while o_instr_valid & ~i_instr_ready.
REQ-024 SHALL, on i_redirect_valid, set pc <= {i_redirect_pc[PC_WIDTH-1:2], 2'b00}, set count <= 0, and perform no push; redirect has priority over push and pop.
REQ-025 SHALL treat a head handshake (pop) in the redirect cycle as completed by decode; the entry is not re-presented.
REQ-026 SHALL ignore i_redirect_pc[1:0].
REQ-027 SHALL wrap o_mem_addr modulo 2^MEM_ADDR_WIDTH when pc exceeds memory range.
REQ-028 SHALL have no combinational path from i_redirect_* to o_instr*; i_instr_ready -> push path permitted.

Reset
REQ-029 SHALL, when i_rstn = 0 at a rising edge, set pc <= RESET_PC, count <= 0; o_instr_valid = 0 the following cycle; reset overrides redirect, push, pop.
REQ-030 SHALL discard FIFO contents on reset asserted mid-operation; first post-reset instruction has o_instr_pc = RESET_PC.
REQ-031 SHALL leave FIFO data storage unreset; only valid/count and pc carry reset values.

Verification
REQ-032 Reset release, mem[k] = 0x1000_0000+k, ready=1 -> o_instr_valid first cycle after release+1; o_instr_pc 0,4,8,... with o_instr 0x1000_0000,0x1000_0001,... one per cycle.
REQ-033 Ready=0 for 5 cycles after first valid -> head holds pc 0, count saturates 2, o_mem_addr frozen at 2; ready=1 -> pcs 0,4,8 delivered with no gap or duplicate.
REQ-034 Redirect to 0x100 while count=2 -> next cycle o_instr_valid=0, o_mem_addr=0x40; following cycle o_instr_pc=0x100.
REQ-035 Redirect to 0x203 -> fetch resumes at 0x200, o_mem_addr=0x80.
REQ-036 Redirect with simultaneous pop of pc 0x8 -> 0x8 delivered exactly once, next delivered pc = redirect target.
REQ-037 PC near top: redirect to 0xFFFF_FFFF_FFFF_FFFC -> delivered pcs ...FFFC then 0x0; o_mem_addr 0x3FF then 0x000; reset mid-stream -> valid drops, restart at RESET_PC.
